// File: rtl/tbm_daq_decoder.sv
// Receive-side parser for the soft TBM DAQ word stream: rebuilds one event record
// per header/payload/trailer readout, flags framing and event-number errors, and counts them.
module tbm_daq_decoder #(
   parameter int CNT_W = 16,
   parameter int PAY_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             daq_write,
   input  logic [15:0]      daq_data,
   input  logic             clear_cnt,
   output logic             evt_valid,
   output logic [7:0]       evt_number,
   output logic [3:0]       evt_trg_pos,
   output logic [7:0]       evt_flags,
   output logic             evt_ares,
   output logic             evt_pkam,
   output logic [3:0]       evt_stack,
   output logic [PAY_W-1:0] evt_payload,
   output logic             err_fmt,
   output logic             err_seq,
   output logic [CNT_W-1:0] evt_cnt,
   output logic [CNT_W-1:0] fmt_cnt,
   output logic [CNT_W-1:0] seq_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, HDR2, PAY, TRL2} state_t;

   state_t state, next_state;

   logic [7:0]       hi_byte;
   logic             is_h1, is_h2, is_t1, is_t2, is_ctl;
   logic             fmt_d, bad, latch_num, latch_trg, inc_pay, latch_flags, complete;
   logic [7:0]       stg_number, stg_flags, prev_num, exp_num;
   logic [3:0]       stg_trg;
   logic [PAY_W-1:0] stg_pay;
   logic             have_prev, seq_bad;

   assign hi_byte = daq_data[15:8];
   assign is_h1   = (hi_byte == 8'hA0);
   assign is_h2   = (hi_byte == 8'h80);
   assign is_t1   = (hi_byte == 8'hE0);
   assign is_t2   = (hi_byte == 8'hC0);
   // Any A/8/E/C nibble is a control word; the ones not matched above are malformed.
   assign is_ctl  = (hi_byte[7:4] == 4'hA) || (hi_byte[7:4] == 4'h8) ||
                    (hi_byte[7:4] == 4'hE) || (hi_byte[7:4] == 4'hC);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state  = state;
      fmt_d       = 1'b0;
      bad         = 1'b0;
      latch_num   = 1'b0;
      latch_trg   = 1'b0;
      inc_pay     = 1'b0;
      latch_flags = 1'b0;
      complete    = 1'b0;
      if (daq_write) begin
         unique case (state)
            IDLE: begin
               if (is_h1) begin
                  latch_num  = 1'b1;
                  next_state = HDR2;
               end else begin
                  fmt_d = 1'b1;
               end
            end
            HDR2: begin
               if (is_h2) begin
                  latch_trg  = 1'b1;
                  next_state = PAY;
               end else begin
                  bad = 1'b1;
               end
            end
            PAY: begin
               if (!is_ctl) begin
                  inc_pay = 1'b1;
               end else if (is_t1) begin
                  latch_flags = 1'b1;
                  next_state  = TRL2;
               end else begin
                  bad = 1'b1;
               end
            end
            TRL2: begin
               if (is_t2) begin
                  complete   = 1'b1;
                  next_state = IDLE;
               end else begin
                  bad = 1'b1;
               end
            end
            default: next_state = IDLE;
         endcase
         // A stray header restarts the event instead of waiting for the next one.
         if (bad) begin
            fmt_d = 1'b1;
            if (is_h1) begin
               latch_num  = 1'b1;
               next_state = HDR2;
            end else begin
               next_state = IDLE;
            end
         end
      end
   end

   assign exp_num = stg_flags[3] ? 8'd0 : prev_num + 8'd1;
   assign seq_bad = have_prev && (stg_number != exp_num);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg_number <= '0;
         stg_trg    <= '0;
         stg_pay    <= '0;
         stg_flags  <= '0;
      end else begin
         if (latch_num)   stg_number <= daq_data[7:0];
         if (latch_trg)   stg_trg    <= daq_data[3:0];
         if (latch_trg)   stg_pay    <= '0;
         else if (inc_pay && !(&stg_pay)) stg_pay <= stg_pay + 1'b1;
         if (latch_flags) stg_flags  <= daq_data[7:0];
      end
   end

   // Published record only changes on completion so readers never see partial fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_valid   <= 1'b0;
         err_seq     <= 1'b0;
         err_fmt     <= 1'b0;
         evt_number  <= '0;
         evt_trg_pos <= '0;
         evt_flags   <= '0;
         evt_ares    <= 1'b0;
         evt_pkam    <= 1'b0;
         evt_stack   <= '0;
         evt_payload <= '0;
      end else begin
         evt_valid <= complete;
         err_seq   <= complete && seq_bad;
         err_fmt   <= fmt_d;
         if (complete) begin
            evt_number  <= stg_number;
            evt_trg_pos <= stg_trg;
            evt_flags   <= stg_flags;
            evt_ares    <= daq_data[7];
            evt_pkam    <= daq_data[6];
            evt_stack   <= daq_data[3:0];
            evt_payload <= stg_pay;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_num  <= '0;
         have_prev <= 1'b0;
      end else begin
         if (complete) begin
            prev_num  <= stg_number;
            have_prev <= 1'b1;
         end
         if (clear_cnt) have_prev <= 1'b0;
      end
   end

   // Counters follow the registered pulses; a clear in the same cycle drops the increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_cnt <= '0;
         fmt_cnt <= '0;
         seq_cnt <= '0;
      end else if (clear_cnt) begin
         evt_cnt <= '0;
         fmt_cnt <= '0;
         seq_cnt <= '0;
      end else begin
         if (evt_valid && !(&evt_cnt)) evt_cnt <= evt_cnt + 1'b1;
         if (err_fmt && !(&fmt_cnt))   fmt_cnt <= fmt_cnt + 1'b1;
         if (err_seq && !(&seq_cnt))   seq_cnt <= seq_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_tbm_daq_decoder.sv
// Scoreboard bench for tbm_daq_decoder: a grammar-level frame model predicts event
// records and framing errors; a negedge monitor pops and compares them.
module tb_tbm_daq_decoder;

   localparam int CNT_W = 16;
   localparam int PAY_W = 12;
   localparam int PAY_MAX = (1 << PAY_W) - 1;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             daq_write;
   logic [15:0]      daq_data;
   logic             clear_cnt;
   logic             evt_valid;
   logic [7:0]       evt_number;
   logic [3:0]       evt_trg_pos;
   logic [7:0]       evt_flags;
   logic             evt_ares;
   logic             evt_pkam;
   logic [3:0]       evt_stack;
   logic [PAY_W-1:0] evt_payload;
   logic             err_fmt;
   logic             err_seq;
   logic [CNT_W-1:0] evt_cnt;
   logic [CNT_W-1:0] fmt_cnt;
   logic [CNT_W-1:0] seq_cnt;
   logic             busy;

   tbm_daq_decoder #(.CNT_W(CNT_W), .PAY_W(PAY_W)) dut (
      .clk(clk), .reset(reset), .daq_write(daq_write), .daq_data(daq_data),
      .clear_cnt(clear_cnt), .evt_valid(evt_valid), .evt_number(evt_number),
      .evt_trg_pos(evt_trg_pos), .evt_flags(evt_flags), .evt_ares(evt_ares),
      .evt_pkam(evt_pkam), .evt_stack(evt_stack), .evt_payload(evt_payload),
      .err_fmt(err_fmt), .err_seq(err_seq), .evt_cnt(evt_cnt), .fmt_cnt(fmt_cnt),
      .seq_cnt(seq_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]       number;
      logic [3:0]       trg;
      logic [7:0]       flags;
      logic             ares;
      logic             pkam;
      logic [3:0]       stack;
      logic [PAY_W-1:0] payload;
      logic             seq;
   } evt_t;

   evt_t        evt_q[$];
   logic [15:0] fmt_q[$];
   logic [15:0] frame[$];
   int          m_evt, m_fmt, m_seq;
   bit          m_have_prev;
   logic [7:0]  m_prev;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // 0 payload, 1 H1, 2 H2, 3 T1, 4 T2, 5 malformed control word
   function automatic int kindOf(input logic [15:0] w);
      case (w[15:8])
         8'hA0: return 1;
         8'h80: return 2;
         8'hE0: return 3;
         8'hC0: return 4;
         default: return (w[15:12] inside {4'hA, 4'h8, 4'hE, 4'hC}) ? 5 : 0;
      endcase
   endfunction

   task automatic finishEvent();
      evt_t       e;
      int         npay;
      logic [7:0] expn;
      logic [15:0] t1, t2;
      t1        = frame[frame.size()-2];
      t2        = frame[frame.size()-1];
      npay      = frame.size() - 4;
      e.number  = frame[0][7:0];
      e.trg     = frame[1][3:0];
      e.flags   = t1[7:0];
      e.ares    = t2[7];
      e.pkam    = t2[6];
      e.stack   = t2[3:0];
      e.payload = PAY_W'((npay > PAY_MAX) ? PAY_MAX : npay);
      expn      = e.flags[3] ? 8'd0 : m_prev + 8'd1;
      e.seq     = m_have_prev && (e.number != expn);
      m_prev      = e.number;
      m_have_prev = 1'b1;
      if (m_evt < CNT_MAX) m_evt++;
      if (e.seq && m_seq < CNT_MAX) m_seq++;
      evt_q.push_back(e);
      frame.delete();
   endtask

   // Frame grammar: H1 H2 P* T1 T2; a stray H1 starts a fresh frame.
   task automatic modelWord(input logic [15:0] w);
      int k, last;
      bit ok;
      k = kindOf(w);
      if (frame.size() == 0) begin
         if (k == 1) frame.push_back(w);
         else begin
            fmt_q.push_back(w);
            if (m_fmt < CNT_MAX) m_fmt++;
         end
         return;
      end
      last = kindOf(frame[frame.size()-1]);
      ok = (last == 1 && k == 2) || ((last == 2 || last == 0) && (k == 0 || k == 3)) ||
           (last == 3 && k == 4);
      if (ok) begin
         frame.push_back(w);
         if (k == 4) finishEvent();
      end else begin
         fmt_q.push_back(w);
         if (m_fmt < CNT_MAX) m_fmt++;
         frame.delete();
         if (k == 1) frame.push_back(w);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] w);
      daq_write = 1'b1;
      daq_data  = w;
      modelWord(w);
      @(posedge clk);
      #1;
      daq_write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkCounters();
      idle(4);
      checkOutput("evt_cnt", 32'(evt_cnt), 32'(m_evt));
      checkOutput("fmt_cnt", 32'(fmt_cnt), 32'(m_fmt));
      checkOutput("seq_cnt", 32'(seq_cnt), 32'(m_seq));
      checkOutput("busy", 32'(busy), 32'(frame.size() != 0));
   endtask

   task automatic clearCounters();
      clear_cnt = 1'b1;
      @(posedge clk);
      #1;
      clear_cnt   = 1'b0;
      m_evt       = 0;
      m_fmt       = 0;
      m_seq       = 0;
      m_have_prev = 1'b0;
   endtask

   task automatic sendEvent(input logic [7:0] num, input logic [7:0] flags, input int npay,
                            input logic [7:0] t2b);
      logic [15:0] w;
      applyStimulus({8'hA0, num});
      w = 16'($urandom);
      applyStimulus({8'h80, w[7:0]});
      for (int i = 0; i < npay; i++) begin
         w = 16'($urandom);
         w[15] = 1'b0;
         applyStimulus(w);
      end
      applyStimulus({8'hE0, flags});
      applyStimulus({8'hC0, t2b});
   endtask

   always @(negedge clk) begin : monitor
      evt_t e;
      if (!reset) begin
         if (err_fmt) begin
            vectors++;
            if (fmt_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL err_fmt: got unexpected pulse, expected none at %0t", $time);
            end else begin
               void'(fmt_q.pop_front());
            end
         end
         if (err_seq && !evt_valid)
            checkOutput("err_seq_alone", 32'(err_seq), 32'd0);
         if (evt_valid) begin
            if (evt_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL evt_valid: got unexpected pulse, expected none at %0t", $time);
            end else begin
               e = evt_q.pop_front();
               checkOutput("evt_number", 32'(evt_number), 32'(e.number));
               checkOutput("evt_trg_pos", 32'(evt_trg_pos), 32'(e.trg));
               checkOutput("evt_flags", 32'(evt_flags), 32'(e.flags));
               checkOutput("evt_ares_pkam", {30'd0, evt_ares, evt_pkam}, {30'd0, e.ares, e.pkam});
               checkOutput("evt_stack", 32'(evt_stack), 32'(e.stack));
               checkOutput("evt_payload", 32'(evt_payload), 32'(e.payload));
               checkOutput("err_seq", 32'(err_seq), 32'(e.seq));
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] words[$];
      logic [7:0]  num;
      logic [7:0]  flags;
      logic [15:0] w;
      bit          sync;
      reset = 1'b1; daq_write = 1'b0; daq_data = '0; clear_cnt = 1'b0;
      m_evt = 0; m_fmt = 0; m_seq = 0; m_have_prev = 1'b0; m_prev = '0;
      idle(3);
      checkOutput("rst_pulses", {29'd0, evt_valid, err_fmt, err_seq}, 32'd0);
      checkOutput("rst_record", {evt_number, evt_flags, evt_trg_pos, evt_stack, 6'd0, evt_ares, evt_pkam},
                  32'd0);
      checkOutput("rst_payload", 32'(evt_payload), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_cnts", 32'(evt_cnt | fmt_cnt | seq_cnt), 32'd0);
      reset = 1'b0;
      idle(1);

      // Basic event
      applyStimulus(16'hA005); applyStimulus(16'h8003); applyStimulus(16'h4123);
      applyStimulus(16'h4456); applyStimulus(16'hE000); applyStimulus(16'hC002);
      checkCounters();
      checkOutput("t1_number", 32'(evt_number), 32'h05);
      checkOutput("t1_trg", 32'(evt_trg_pos), 32'h3);
      checkOutput("t1_payload", 32'(evt_payload), 32'd2);
      checkOutput("t1_stack", 32'(evt_stack), 32'd2);
      checkOutput("t1_evt_cnt", 32'(evt_cnt), 32'd1);
      clearCounters();

      // Sequence gap then sync reset of numbering
      sendEvent(8'h05, 8'h00, 1, 8'h00);
      sendEvent(8'h06, 8'h00, 0, 8'h00);
      sendEvent(8'h08, 8'h00, 2, 8'h00);
      checkCounters();
      checkOutput("t2_seq_cnt", 32'(seq_cnt), 32'd1);
      sendEvent(8'h00, 8'h08, 0, 8'h00);
      checkCounters();
      checkOutput("t2_seq_after_sync", 32'(seq_cnt), 32'd1);

      // Zero payload with trailer bits
      applyStimulus(16'hA010); applyStimulus(16'h8000);
      applyStimulus(16'hE080); applyStimulus(16'hC0C0);
      checkCounters();
      checkOutput("t3_flags", 32'(evt_flags), 32'h80);
      checkOutput("t3_ares_pkam", {30'd0, evt_ares, evt_pkam}, 32'd3);
      checkOutput("t3_payload", 32'(evt_payload), 32'd0);
      clearCounters();

      // Header restart inside payload
      applyStimulus(16'hA001); applyStimulus(16'h8000); applyStimulus(16'h4111);
      applyStimulus(16'hA002); applyStimulus(16'h8001); applyStimulus(16'hE000);
      applyStimulus(16'hC000);
      checkCounters();
      checkOutput("t4_number", 32'(evt_number), 32'h02);
      checkOutput("t4_fmt_cnt", 32'(fmt_cnt), 32'd1);

      // Garbage while idle, then clear
      applyStimulus(16'h4111);
      checkOutput("t5_busy_a", 32'(busy), 32'd0);
      applyStimulus(16'hB100);
      checkOutput("t5_busy_b", 32'(busy), 32'd0);
      checkCounters();
      clearCounters();
      idle(1);
      checkOutput("t5_cleared", 32'(evt_cnt | fmt_cnt | seq_cnt), 32'd0);

      // Reset mid-event
      applyStimulus(16'hA001); applyStimulus(16'h8000);
      #2 reset = 1'b1;
      #1 checkOutput("t6_busy", 32'(busy), 32'd0);
      frame.delete();
      m_evt = 0; m_fmt = 0; m_seq = 0; m_have_prev = 1'b0;
      idle(1);
      reset = 1'b0;
      idle(1);
      sendEvent(8'h33, 8'h00, 3, 8'h05);
      checkCounters();

      // Randomized traffic with occasional corruption and clears
      num = 8'h40;
      for (int ev = 0; ev < 300; ev++) begin
         sync  = ($urandom_range(0, 9) == 0);
         flags = 8'($urandom) & 8'hF7;
         if (sync) begin
            num = 8'h00;
            flags[3] = 1'b1;
         end else if ($urandom_range(0, 9) == 0) begin
            num = 8'($urandom);
         end else begin
            num = num + 8'd1;
         end
         words.delete();
         words.push_back({8'hA0, num});
         w = 16'($urandom);
         words.push_back({8'h80, w[7:0]});
         for (int i = 0; i < $urandom_range(0, 6); i++) begin
            w = 16'($urandom);
            w[15] = 1'b0;
            words.push_back(w);
         end
         words.push_back({8'hE0, flags});
         w = 16'($urandom);
         words.push_back({8'hC0, w[7:0]});
         if ($urandom_range(0, 4) == 0)
            words.insert($urandom_range(0, words.size()), 16'($urandom));
         foreach (words[i]) begin
            applyStimulus(words[i]);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
         if (ev % 60 == 59) begin
            checkCounters();
            clearCounters();
         end
      end
      checkCounters();

      // Payload counter saturation
      sendEvent(num + 8'd1, 8'h00, PAY_MAX + 5, 8'h01);
      checkCounters();
      checkOutput("sat_payload", 32'(evt_payload), 32'(PAY_MAX));

      idle(3);
      checkOutput("evt_q_left", 32'(evt_q.size()), 32'd0);
      checkOutput("fmt_q_left", 32'(fmt_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
